ahb_rr_arbiter: RTL and testbench
=================================

Name: ahb_rr_arbiter

Overview:
- Round-robin bus arbiter for the AHB interface. Shares one AHB-lite slave port among NUM_MST masters.
- Generates per-master grants and the registered select codes that steer the wide address/control mux and the write-data mux. Those muxes are universal muxes with SEL = master index.
- Handles burst integrity, locked sequences and bus parking on a default master.

Parameters:
- NUM_MST, 4, number of requesting masters (2..16).
- SEL_W, 2, width of select codes; must satisfy 2**SEL_W >= NUM_MST.
- DEFAULT_MST, 0, master parked on the bus when nobody requests; must be < NUM_MST.

Ports:
- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HBUSREQ  in  NUM_MST  bus request, bit i = master i.
- HLOCK  in  NUM_MST  lock request, bit i = master i.
- HTRANS  in  2  transfer type from the currently muxed master: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HREADY  in  1  bus ready from slave response mux.
- HGRANT  out  NUM_MST  one-hot grant.
- HMASTER  out  SEL_W  address-phase mux select (index of owning master).
- HMASTER_D  out  SEL_W  data-phase mux select (write-data mux).
- HMASTLOCK  out  1  current address phase is locked.

Behaviour:
- Reset (HRESETn low, asynchronous): HGRANT = one-hot(DEFAULT_MST); HMASTER = HMASTER_D = DEFAULT_MST; HMASTLOCK = 0; state PARK; rr pointer = DEFAULT_MST.
- Reset applied mid-burst: it overrides everything immediately. No transfer is completed.
- Arbitration point (AP): a cycle with HREADY=1 and HTRANS in {IDLE, NONSEQ}, with state not LOCKED.
  - No AP occurs while HTRANS is SEQ or BUSY. Bursts are never broken.
- Winner at an AP: the first i with HBUSREQ[i]=1, scanning from (rr_ptr+1) mod NUM_MST upward with wrap. rr_ptr itself is scanned last.
  - No requester: winner = DEFAULT_MST, next state PARK.
  - Winner found: rr_ptr <= winner and HGRANT <= one-hot(winner), registered so visible the cycle after the AP.
  - Next state: LOCKED if HLOCK[winner]=1, else OWN.
- States:
  - PARK: default master granted; it may issue transfers with no request.
  - OWN: a requester is granted; re-arbitrated at every AP.
  - LOCKED: grant frozen.
- LOCKED exit: only in a cycle with HREADY=1, HLOCK[owner]=0 and HTRANS=IDLE. That cycle is then treated as an AP.
- Owner keeps requesting at an AP: it wins only if no other master requests. This gives fairness.
- Select pipeline, both updating only when HREADY=1:
  - HMASTER <= index(HGRANT); HMASTLOCK <= HLOCK[index(HGRANT)].
  - HMASTER_D <= HMASTER.
  - When HREADY=0, all three outputs hold.
  - Latency: request to HGRANT is 1 cycle after the AP; HGRANT to HMASTER is 1 HREADY cycle; HMASTER to HMASTER_D is 1 HREADY cycle.
- HMASTER and HMASTER_D are always < NUM_MST. Unused select codes are never driven.
- HGRANT is always exactly one-hot.
- Simultaneous requests are resolved purely by the rr order.
- A request that drops in the same cycle as an AP is not considered.
- HLOCK without HBUSREQ is ignored.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ).
  - arbiter state enum (PARK, OWN, LOCKED).
  - function onehot-to-index.
- Sub-module ahb_rr_pick: purely combinational.
  - Inputs: request vector, pointer.
  - Outputs: winner index, found flag.
  - Implemented as a rotate plus priority search.
- The top module holds the FSM, pointer, grant register and select pipeline.

Test Plan:
- Reset and parking: hold HRESETn=0, then release with no requests -> HGRANT=4'b0001, HMASTER=0, HMASTER_D=0, HMASTLOCK=0, and these persist.
- Round-robin fairness: HBUSREQ=4'b1111, HTRANS=NONSEQ, HREADY=1 every cycle -> grants rotate 1,2,3,0,1…, and HMASTER follows one cycle behind HGRANT.
- Burst integrity: master 2 owns the bus and drives NONSEQ then 3×SEQ while master 3 requests -> HGRANT stays 4'b0100 through the SEQ beats and moves to 4'b1000 only after the AP at the next NONSEQ/IDLE.
- Wait states: HREADY=0 for 3 cycles during a handover -> HMASTER and HMASTER_D hold. After HREADY=1, HMASTER_D equals the previous HMASTER.
- Lock: master 1 asserts HBUSREQ and HLOCK, wins, and master 0 requests throughout -> HMASTLOCK=1, grant frozen on master 1. After HLOCK=0 with HTRANS=IDLE and HREADY=1, the grant passes to master 0 on the next cycle.
- Async reset mid-burst: drop HRESETn during a SEQ beat of master 3 -> outputs return to reset values without waiting for an HCLK edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: HTRANS encodings, arbiter state enum and a one-hot decoder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam int MAX_MST = 16;

  typedef enum logic [1:0] {
    ARB_PARK,
    ARB_OWN,
    ARB_LOCKED
  } arb_state_e;

  // OR-reduction decoder; only meaningful for a one-hot input.
  function automatic logic [3:0] onehot_to_index(input logic [MAX_MST-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MST; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr+1 sits at bit 0, then take the lowest set bit.
module ahb_rr_pick #(
  parameter int NUM_MST = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);

  logic [NUM_MST-1:0] rot;
  int                 start;

  always_comb begin
    start = (int'(ptr) + 1) % NUM_MST;
    rot   = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      for (int k = 0; k < NUM_MST; k++) begin
        if (((start + k) % NUM_MST) == i) rot[k] = req[i];
      end
    end

    found  = 1'b0;
    winner = '0;
    // Descending scan so the lowest rotated position wins; ptr itself lands at the top, scanned last.
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found  = 1'b1;
        winner = SEL_W'((start + k) % NUM_MST);
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB-lite arbiter: PARK/OWN/LOCKED FSM, rr pointer, registered grant and select pipeline.
module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MST     = 4,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_MST = 0
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NUM_MST-1:0] HBUSREQ,
  input  logic [NUM_MST-1:0] HLOCK,
  input  logic [1:0]         HTRANS,
  input  logic               HREADY,
  output logic [NUM_MST-1:0] HGRANT,
  output logic [SEL_W-1:0]   HMASTER,
  output logic [SEL_W-1:0]   HMASTER_D,
  output logic               HMASTLOCK
);

  localparam logic [NUM_MST-1:0] DEF_OH  = NUM_MST'(1) << DEFAULT_MST;
  localparam logic [SEL_W-1:0]   DEF_IDX = SEL_W'(DEFAULT_MST);

  arb_state_e         state, state_next;
  logic [SEL_W-1:0]   rr_ptr, rr_ptr_next;
  logic [NUM_MST-1:0] grant, grant_next;
  logic [SEL_W-1:0]   owner;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic               gap_beat;
  logic               arb_point;

  assign owner  = SEL_W'(onehot_to_index(MAX_MST'(grant)));
  assign HGRANT = grant;

  ahb_rr_pick #(
    .NUM_MST (NUM_MST),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req    (HBUSREQ),
    .ptr    (rr_ptr),
    .winner (pick_idx),
    .found  (pick_found)
  );

  // Only IDLE/NONSEQ beats may end an ownership; SEQ/BUSY keep a burst intact.
  always_comb begin
    gap_beat = 1'b0;
    case (HTRANS)
      HTRANS_IDLE, HTRANS_NONSEQ: gap_beat = 1'b1;
      HTRANS_BUSY, HTRANS_SEQ:    gap_beat = 1'b0;
      default:                    gap_beat = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    grant_next  = grant;

    if (state == ARB_LOCKED)
      arb_point = HREADY && !HLOCK[owner] && (HTRANS == HTRANS_IDLE);
    else
      arb_point = HREADY && gap_beat;

    if (arb_point) begin
      if (pick_found) begin
        rr_ptr_next          = pick_idx;
        grant_next           = '0;
        grant_next[pick_idx] = 1'b1;
        state_next           = HLOCK[pick_idx] ? ARB_LOCKED : ARB_OWN;
      end else begin
        grant_next = DEF_OH;
        state_next = ARB_PARK;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= ARB_PARK;
      rr_ptr <= DEF_IDX;
      grant  <= DEF_OH;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
      grant  <= grant_next;
    end
  end

  // HREADY=1 completes the current beat: address-phase select moves on and data phase inherits it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HMASTER   <= DEF_IDX;
      HMASTER_D <= DEF_IDX;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      HMASTER   <= owner;
      HMASTLOCK <= HLOCK[owner];
      HMASTER_D <= HMASTER;
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: expected {HGRANT,HMASTER,HMASTER_D,HMASTLOCK} queued per step, checked after each edge.
module tb_ahb_rr_arbiter;

  localparam int NUM_MST = 4;
  localparam int SEL_W   = 2;
  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  logic               HCLK = 1'b0;
  logic               HRESETn;
  logic [NUM_MST-1:0] HBUSREQ;
  logic [NUM_MST-1:0] HLOCK;
  logic [1:0]         HTRANS;
  logic               HREADY;
  logic [NUM_MST-1:0] HGRANT;
  logic [SEL_W-1:0]   HMASTER;
  logic [SEL_W-1:0]   HMASTER_D;
  logic               HMASTLOCK;

  logic [8:0] exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  ahb_rr_arbiter #(
    .NUM_MST     (NUM_MST),
    .SEL_W       (SEL_W),
    .DEFAULT_MST (0)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  function automatic logic [8:0] pk(input logic [3:0] g, input int hm, input int hmd, input logic ml);
    return {g, 2'(hm), 2'(hmd), ml};
  endfunction

  // scoreboard
  task automatic check(input string tag);
    logic [8:0] e;
    logic [8:0] o;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    o = {HGRANT, HMASTER, HMASTER_D, HMASTLOCK};
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed grant/hm/hmd/lock=%b_%0d_%0d_%b expected=%b_%0d_%0d_%b",
             tag, o[8:5], o[4:3], o[2:1], o[0], e[8:5], e[4:3], e[2:1], e[0]);
    end
  endtask

  // driver: apply one cycle of inputs, queue the expected post-edge outputs, compare after the edge
  task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] lock,
                     input logic [1:0] trans, input logic ready, input logic [8:0] e);
    HBUSREQ = req;
    HLOCK   = lock;
    HTRANS  = trans;
    HREADY  = ready;
    exp_q.push_back(e);
    @(posedge HCLK);
    #1;
    check(tag);
  endtask

  always @(negedge HCLK) begin
    if (HRESETn === 1'b1) begin
      n_chk++;
      assert ($onehot(HGRANT)) else begin
        n_fail++;
        $error("FAIL grant_onehot observed=%b expected one-hot", HGRANT);
      end
    end
  end

  initial begin
    HRESETn = 1'b0;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = T_IDLE;
    HREADY  = 1'b1;
    #12;
    exp_q.push_back(pk(4'b0001, 0, 0, 0));
    check("in_reset");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // parking
    for (int i = 0; i < 3; i++) cyc("park", 4'b0000, 4'b0000, T_IDLE, 1'b1, pk(4'b0001, 0, 0, 0));

    // round-robin with everyone requesting
    cyc("rr_1", 4'b1111, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0010, 0, 0, 0));
    cyc("rr_2", 4'b1111, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0100, 1, 0, 0));
    cyc("rr_3", 4'b1111, 4'b0000, T_NONSEQ, 1'b1, pk(4'b1000, 2, 1, 0));
    cyc("rr_0", 4'b1111, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0001, 3, 2, 0));
    cyc("rr_1b", 4'b1111, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0010, 0, 3, 0));

    // burst integrity: master 2 bursts while master 3 requests
    cyc("burst_win", 4'b0100, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0100, 1, 0, 0));
    cyc("burst_nseq", 4'b0100, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0100, 2, 1, 0));
    for (int i = 0; i < 3; i++) cyc("burst_seq", 4'b1100, 4'b0000, T_SEQ, 1'b1, pk(4'b0100, 2, 2, 0));
    cyc("burst_end", 4'b1000, 4'b0000, T_IDLE, 1'b1, pk(4'b1000, 2, 2, 0));
    cyc("burst_next", 4'b1000, 4'b0000, T_NONSEQ, 1'b1, pk(4'b1000, 3, 2, 0));

    // wait states around a handover
    cyc("ws_handover", 4'b0001, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0001, 3, 3, 0));
    for (int i = 0; i < 3; i++) cyc("ws_hold", 4'b0010, 4'b0000, T_NONSEQ, 1'b0, pk(4'b0001, 3, 3, 0));
    cyc("ws_release", 4'b0010, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0010, 0, 3, 0));

    // locked sequence by master 1 while master 0 keeps requesting
    cyc("lk_prep", 4'b0001, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0001, 1, 0, 0));
    cyc("lk_win", 4'b0011, 4'b0010, T_IDLE, 1'b1, pk(4'b0010, 0, 1, 0));
    cyc("lk_nseq", 4'b0011, 4'b0010, T_NONSEQ, 1'b1, pk(4'b0010, 1, 0, 1));
    cyc("lk_seq", 4'b0011, 4'b0010, T_SEQ, 1'b1, pk(4'b0010, 1, 1, 1));
    cyc("lk_idle_held", 4'b0011, 4'b0010, T_IDLE, 1'b1, pk(4'b0010, 1, 1, 1));
    cyc("lk_drop_nseq", 4'b0011, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0010, 1, 1, 0));
    cyc("lk_exit", 4'b0011, 4'b0000, T_IDLE, 1'b1, pk(4'b0001, 1, 1, 0));
    cyc("lk_after", 4'b0001, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0001, 0, 1, 0));

    // HLOCK without HBUSREQ is ignored; a plain win is not locked
    cyc("lock_noreq", 4'b0000, 4'b0100, T_IDLE, 1'b1, pk(4'b0001, 0, 0, 0));
    cyc("own_2", 4'b0100, 4'b0000, T_NONSEQ, 1'b1, pk(4'b0100, 0, 0, 0));
    cyc("own_3", 4'b1000, 4'b0000, T_NONSEQ, 1'b1, pk(4'b1000, 2, 0, 0));

    // asynchronous reset in the middle of a master 3 burst
    cyc("ar_nseq", 4'b1000, 4'b0000, T_NONSEQ, 1'b1, pk(4'b1000, 3, 2, 0));
    cyc("ar_seq", 4'b1000, 4'b0000, T_SEQ, 1'b1, pk(4'b1000, 3, 3, 0));
    HTRANS = T_SEQ;
    #2;
    HRESETn = 1'b0;
    #1;
    exp_q.push_back(pk(4'b0001, 0, 0, 0));
    check("ar_async");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    cyc("ar_park_seq", 4'b1000, 4'b0000, T_SEQ, 1'b1, pk(4'b0001, 0, 0, 0));
    cyc("ar_park_idle", 4'b0000, 4'b0000, T_IDLE, 1'b1, pk(4'b0001, 0, 0, 0));

    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
